// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU issue stage.
//   - ALU_OP_W and one-hot bit indices of alu_op (add .. lui).
//   - Opcode match constants for the 3R (inst[31:15]), 2RI12 (inst[31:22])
//     and 1RI20 (inst[31:25]) instruction fields.
//   - Immediate-select encoding and small helper functions.
package alu_pkg;

    localparam int ALU_OP_W = 12;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLT  = 2;
    localparam int OP_SLTU = 3;
    localparam int OP_AND  = 4;
    localparam int OP_NOR  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_SLL  = 8;
    localparam int OP_SRL  = 9;
    localparam int OP_SRA  = 10;
    localparam int OP_LUI  = 11;

    // 3R and shift-immediate forms, matched on inst[31:15]
    localparam logic [16:0] OPC_ADD_W  = 17'h00020;
    localparam logic [16:0] OPC_SUB_W  = 17'h00022;
    localparam logic [16:0] OPC_SLT    = 17'h00024;
    localparam logic [16:0] OPC_SLTU   = 17'h00025;
    localparam logic [16:0] OPC_NOR    = 17'h00028;
    localparam logic [16:0] OPC_AND    = 17'h00029;
    localparam logic [16:0] OPC_OR     = 17'h0002A;
    localparam logic [16:0] OPC_XOR    = 17'h0002B;
    localparam logic [16:0] OPC_SLL_W  = 17'h0002E;
    localparam logic [16:0] OPC_SRL_W  = 17'h0002F;
    localparam logic [16:0] OPC_SRA_W  = 17'h00030;
    localparam logic [16:0] OPC_SLLI_W = 17'h00081;
    localparam logic [16:0] OPC_SRLI_W = 17'h00089;
    localparam logic [16:0] OPC_SRAI_W = 17'h00091;

    // 2RI12 forms, matched on inst[31:22]
    localparam logic [9:0] OPC_SLTI   = 10'h008;
    localparam logic [9:0] OPC_SLTUI  = 10'h009;
    localparam logic [9:0] OPC_ADDI_W = 10'h00A;
    localparam logic [9:0] OPC_ANDI   = 10'h00D;
    localparam logic [9:0] OPC_ORI    = 10'h00E;
    localparam logic [9:0] OPC_XORI   = 10'h00F;

    // 1RI20 form, matched on inst[31:25]
    localparam logic [6:0] OPC_LU12I_W = 7'h0A;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_SI12 = 3'd1,
        IMM_UI12 = 3'd2,
        IMM_UI5  = 3'd3,
        IMM_SI20 = 3'd4
    } imm_sel_t;

    function automatic logic [ALU_OP_W-1:0] op_onehot(input int idx);
        return {{(ALU_OP_W-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/alu_inst_decode.sv
// alu_inst_decode: purely combinational decoder for the LoongArch integer
// ALU subset.
//   inst      : instruction word held by the issue stage
//   alu_op    : one-hot ALU operation (0 for an undecoded instruction)
//   use_imm   : the non-rj operand is the immediate instead of the rk value
//   imm       : extended immediate (si12/ui12/ui5/si20<<12)
//   src_swap  : rj value goes to alu_src2 and the other operand to alu_src1
//   src1_zero : alu_src1 is forced to zero (lu12i.w)
//   uses_rj   : rj is a real source register (hazard relevant)
//   uses_rk   : rk is a real source register (3R register forms only)
//   rj/rk/rd  : register fields
//   rf_we     : decoded op writes back and rd is not r0
//   illegal   : instruction is outside the decoded subset
module alu_inst_decode
    import alu_pkg::*;
(
    input  logic [31:0]         inst,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                use_imm,
    output logic [31:0]         imm,
    output logic                src_swap,
    output logic                src1_zero,
    output logic                uses_rj,
    output logic                uses_rk,
    output logic [4:0]          rj,
    output logic [4:0]          rk,
    output logic [4:0]          rd,
    output logic                rf_we,
    output logic                illegal
);

    imm_sel_t imm_sel_s;
    logic     legal_s;

    assign rj = inst[9:5];
    assign rk = inst[14:10];
    assign rd = inst[4:0];

    // Opcode match: selects op, immediate kind and operand routing.
    always_comb begin
        alu_op    = '0;
        imm_sel_s = IMM_NONE;
        src_swap  = 1'b0;
        src1_zero = 1'b0;
        uses_rj   = 1'b0;
        uses_rk   = 1'b0;
        legal_s   = 1'b0;
        if (inst[31:25] == OPC_LU12I_W) begin
            alu_op    = op_onehot(OP_LUI);
            imm_sel_s = IMM_SI20;
            src1_zero = 1'b1;
            legal_s   = 1'b1;
        end else begin
            legal_s = 1'b1;
            uses_rj = 1'b1;
            // 3R opcodes all have inst[31:22] of 0 or 1, so they never
            // collide with the 2RI12 codes and fall through to the inner case.
            case (inst[31:22])
                OPC_SLTI:   begin alu_op = op_onehot(OP_SLT);  imm_sel_s = IMM_SI12; src_swap = 1'b1; end
                OPC_SLTUI:  begin alu_op = op_onehot(OP_SLTU); imm_sel_s = IMM_SI12; src_swap = 1'b1; end
                OPC_ADDI_W: begin alu_op = op_onehot(OP_ADD);  imm_sel_s = IMM_SI12; src_swap = 1'b1; end
                OPC_ANDI:   begin alu_op = op_onehot(OP_AND);  imm_sel_s = IMM_UI12; end
                OPC_ORI:    begin alu_op = op_onehot(OP_OR);   imm_sel_s = IMM_UI12; end
                OPC_XORI:   begin alu_op = op_onehot(OP_XOR);  imm_sel_s = IMM_UI12; end
                default: begin
                    case (inst[31:15])
                        OPC_ADD_W:  begin alu_op = op_onehot(OP_ADD);  src_swap = 1'b1; uses_rk = 1'b1; end
                        OPC_SUB_W:  begin alu_op = op_onehot(OP_SUB);  src_swap = 1'b1; uses_rk = 1'b1; end
                        OPC_SLT:    begin alu_op = op_onehot(OP_SLT);  src_swap = 1'b1; uses_rk = 1'b1; end
                        OPC_SLTU:   begin alu_op = op_onehot(OP_SLTU); src_swap = 1'b1; uses_rk = 1'b1; end
                        OPC_NOR:    begin alu_op = op_onehot(OP_NOR);  uses_rk = 1'b1; end
                        OPC_AND:    begin alu_op = op_onehot(OP_AND);  uses_rk = 1'b1; end
                        OPC_OR:     begin alu_op = op_onehot(OP_OR);   uses_rk = 1'b1; end
                        OPC_XOR:    begin alu_op = op_onehot(OP_XOR);  uses_rk = 1'b1; end
                        OPC_SLL_W:  begin alu_op = op_onehot(OP_SLL);  uses_rk = 1'b1; end
                        OPC_SRL_W:  begin alu_op = op_onehot(OP_SRL);  src_swap = 1'b1; uses_rk = 1'b1; end
                        OPC_SRA_W:  begin alu_op = op_onehot(OP_SRA);  src_swap = 1'b1; uses_rk = 1'b1; end
                        OPC_SLLI_W: begin alu_op = op_onehot(OP_SLL);  imm_sel_s = IMM_UI5; end
                        OPC_SRLI_W: begin alu_op = op_onehot(OP_SRL);  imm_sel_s = IMM_UI5; src_swap = 1'b1; end
                        OPC_SRAI_W: begin alu_op = op_onehot(OP_SRA);  imm_sel_s = IMM_UI5; src_swap = 1'b1; end
                        default: begin
                            // Undecoded: no register sources, so it never stalls.
                            legal_s = 1'b0;
                            uses_rj = 1'b0;
                        end
                    endcase
                end
            endcase
        end
    end

    // Immediate extension according to the selected format.
    always_comb begin
        case (imm_sel_s)
            IMM_SI12: imm = sext12(inst[21:10]);
            IMM_UI12: imm = {20'h00000, inst[21:10]};
            IMM_UI5:  imm = {27'h0000000, inst[14:10]};
            IMM_SI20: imm = {inst[24:5], 12'h000};
            default:  imm = 32'h00000000;
        endcase
    end

    assign use_imm = (imm_sel_s != IMM_NONE);
    assign illegal = ~legal_s;
    assign rf_we   = legal_s & (rd != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue pipeline stage feeding the execute ALU.
//   clk, resetn          : clock, asynchronous active-low reset
//   fs_valid/pc/inst     : fetch packet in; ds_allowin accepts it
//   flush                : drop the held instruction
//   rf_raddr1/2, rf_rdata1/2 : register-file read port (rj, rk)
//   dst_valid/dst_addr   : downstream destination registers (slot 0 = EX)
//   es_allowin           : EX accepts a packet
//   ds_to_es_valid, ds_pc, alu_op, alu_src1, alu_src2, dest, rf_we,
//   inst_illegal         : issue packet to EX
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int NUM_FWD = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 fs_valid,
    input  logic [PC_W-1:0]      fs_pc,
    input  logic [31:0]          fs_inst,
    output logic                 ds_allowin,
    input  logic                 flush,
    output logic [4:0]           rf_raddr1,
    output logic [4:0]           rf_raddr2,
    input  logic [31:0]          rf_rdata1,
    input  logic [31:0]          rf_rdata2,
    input  logic [NUM_FWD-1:0]   dst_valid,
    input  logic [5*NUM_FWD-1:0] dst_addr,
    input  logic                 es_allowin,
    output logic                 ds_to_es_valid,
    output logic [PC_W-1:0]      ds_pc,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [31:0]          alu_src1,
    output logic [31:0]          alu_src2,
    output logic [4:0]           dest,
    output logic                 rf_we,
    output logic                 inst_illegal
);

    logic            ds_valid_r;
    logic [PC_W-1:0] ds_pc_r;
    logic [31:0]     ds_inst_r;

    logic [ALU_OP_W-1:0] dec_op_s;
    logic                dec_use_imm_s;
    logic [31:0]         dec_imm_s;
    logic                dec_swap_s;
    logic                dec_src1_zero_s;
    logic                dec_uses_rj_s;
    logic                dec_uses_rk_s;
    logic [4:0]          rj_s;
    logic [4:0]          rk_s;
    logic [4:0]          rd_s;
    logic                dec_rf_we_s;
    logic                dec_illegal_s;

    logic                hazard_s;
    logic                ds_ready_go_s;
    logic [31:0]         opnd_s;

    alu_inst_decode u_decode (
        .inst      (ds_inst_r),
        .alu_op    (dec_op_s),
        .use_imm   (dec_use_imm_s),
        .imm       (dec_imm_s),
        .src_swap  (dec_swap_s),
        .src1_zero (dec_src1_zero_s),
        .uses_rj   (dec_uses_rj_s),
        .uses_rk   (dec_uses_rk_s),
        .rj        (rj_s),
        .rk        (rk_s),
        .rd        (rd_s),
        .rf_we     (dec_rf_we_s),
        .illegal   (dec_illegal_s)
    );

    assign ds_ready_go_s  = ~hazard_s;
    assign ds_allowin     = ~ds_valid_r | (ds_ready_go_s & es_allowin);
    assign ds_to_es_valid = ds_valid_r & ds_ready_go_s & ~flush;

    // Stage register: flush beats load, load only when the stage can accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid_r <= 1'b0;
            ds_pc_r    <= '0;
            ds_inst_r  <= 32'h00000000;
        end else if (flush) begin
            ds_valid_r <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid_r <= fs_valid;
            if (fs_valid) begin
                ds_pc_r   <= fs_pc;
                ds_inst_r <= fs_inst;
            end
        end
    end

    // RAW interlock against every valid downstream destination except r0.
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (dst_valid[i] && (dst_addr[i*5 +: 5] != 5'd0) &&
                ((dec_uses_rj_s && (dst_addr[i*5 +: 5] == rj_s)) ||
                 (dec_uses_rk_s && (dst_addr[i*5 +: 5] == rk_s)))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    assign opnd_s = dec_use_imm_s ? dec_imm_s : rf_rdata2;

    // Packet outputs; an empty stage or illegal instruction drives zeros.
    always_comb begin
        alu_op       = '0;
        alu_src1     = 32'h00000000;
        alu_src2     = 32'h00000000;
        rf_we        = 1'b0;
        inst_illegal = 1'b0;
        if (ds_valid_r) begin
            alu_op       = dec_op_s;
            rf_we        = dec_rf_we_s;
            inst_illegal = dec_illegal_s;
            if (dec_illegal_s) begin
                alu_src1 = 32'h00000000;
                alu_src2 = 32'h00000000;
            end else if (dec_src1_zero_s) begin
                alu_src1 = 32'h00000000;
                alu_src2 = dec_imm_s;
            end else if (dec_swap_s) begin
                alu_src1 = opnd_s;
                alu_src2 = rf_rdata1;
            end else begin
                alu_src1 = rf_rdata1;
                alu_src2 = opnd_s;
            end
        end else begin
            alu_op = '0;
        end
    end

    assign ds_pc     = ds_pc_r;
    assign dest      = rd_s;
    assign rf_raddr1 = rj_s;
    assign rf_raddr2 = rk_s;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized self-checking bench for
// alu_issue_stage against a behavioural model of the issue stage.
module tb_alu_issue_stage;

    localparam int PC_W = 32;
    localparam int NF   = 3;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            fs_valid, flush, es_allowin;
    logic [PC_W-1:0] fs_pc;
    logic [31:0]     fs_inst;
    logic            ds_allowin, ds_to_es_valid, rf_we, inst_illegal;
    logic [4:0]      rf_raddr1, rf_raddr2, dest;
    logic [31:0]     rf_rdata1, rf_rdata2, alu_src1, alu_src2;
    logic [NF-1:0]   dst_valid;
    logic [5*NF-1:0] dst_addr;
    logic [PC_W-1:0] ds_pc;
    logic [11:0]     alu_op;

    logic [31:0] regs [32];
    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    alu_issue_stage #(.PC_W(PC_W), .NUM_FWD(NF)) dut (
        .clk(clk), .resetn(resetn), .fs_valid(fs_valid), .fs_pc(fs_pc),
        .fs_inst(fs_inst), .ds_allowin(ds_allowin), .flush(flush),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
        .rf_rdata2(rf_rdata2), .dst_valid(dst_valid), .dst_addr(dst_addr),
        .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid), .ds_pc(ds_pc),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .dest(dest),
        .rf_we(rf_we), .inst_illegal(inst_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [11:0] op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        ill;
        logic        we;
        logic        urj;
        logic        urk;
    } exp_t;

    localparam logic [16:0] OP3 [14] = '{17'h20, 17'h22, 17'h24, 17'h25, 17'h28, 17'h29, 17'h2A,
                                         17'h2B, 17'h2E, 17'h2F, 17'h30, 17'h81, 17'h89, 17'h91};
    localparam logic [9:0]  OP2 [6]  = '{10'h008, 10'h009, 10'h00A, 10'h00D, 10'h00E, 10'h00F};

    function automatic exp_t blank();
        exp_t e;
        e.op = 12'h000; e.s1 = 32'h0; e.s2 = 32'h0;
        e.ill = 1'b0; e.we = 1'b0; e.urj = 1'b0; e.urk = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk(input int b, input logic [31:0] a1, input logic [31:0] a2,
                                input logic urk, input logic [4:0] rd);
        exp_t e;
        e = blank();
        e.op[b] = 1'b1;
        e.s1 = a1; e.s2 = a2;
        e.we = (rd != 5'd0); e.urj = 1'b1; e.urk = urk;
        return e;
    endfunction

    // What EX must receive for instruction i, in ALU-contract terms.
    function automatic exp_t model_decode(input logic [31:0] i);
        exp_t e;
        logic [31:0] vj, vk, si12, ui12, ui5;
        logic [4:0]  rd;
        vj   = regs[i[9:5]];
        vk   = regs[i[14:10]];
        si12 = {{20{i[21]}}, i[21:10]};
        ui12 = {20'h0, i[21:10]};
        ui5  = {27'h0, i[14:10]};
        rd   = i[4:0];
        e = blank();
        e.ill = 1'b1;
        if (i[31:25] == 7'h0A) begin
            e = mk(11, 32'h0, {i[24:5], 12'h000}, 1'b0, rd);
            e.urj = 1'b0;
        end else begin
            case (i[31:22])
                10'h008: e = mk(2, si12, vj, 1'b0, rd);
                10'h009: e = mk(3, si12, vj, 1'b0, rd);
                10'h00A: e = mk(0, si12, vj, 1'b0, rd);
                10'h00D: e = mk(4, vj, ui12, 1'b0, rd);
                10'h00E: e = mk(6, vj, ui12, 1'b0, rd);
                10'h00F: e = mk(7, vj, ui12, 1'b0, rd);
                default: begin
                    case (i[31:15])
                        17'h20: e = mk(0, vk, vj, 1'b1, rd);
                        17'h22: e = mk(1, vk, vj, 1'b1, rd);
                        17'h24: e = mk(2, vk, vj, 1'b1, rd);
                        17'h25: e = mk(3, vk, vj, 1'b1, rd);
                        17'h28: e = mk(5, vj, vk, 1'b1, rd);
                        17'h29: e = mk(4, vj, vk, 1'b1, rd);
                        17'h2A: e = mk(6, vj, vk, 1'b1, rd);
                        17'h2B: e = mk(7, vj, vk, 1'b1, rd);
                        17'h2E: e = mk(8, vj, vk, 1'b1, rd);
                        17'h2F: e = mk(9, vk, vj, 1'b1, rd);
                        17'h30: e = mk(10, vk, vj, 1'b1, rd);
                        17'h81: e = mk(8, vj, ui5, 1'b0, rd);
                        17'h89: e = mk(9, ui5, vj, 1'b0, rd);
                        17'h91: e = mk(10, ui5, vj, 1'b0, rd);
                        default: e.ill = 1'b1;
                    endcase
                end
            endcase
        end
        return e;
    endfunction

    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_inst  = 32'h0;
    int          acc_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] issued_log[$];

    function automatic logic model_hazard();
        exp_t e;
        logic [4:0] a;
        e = model_decode(m_inst);
        for (int s = 0; s < NF; s++) begin
            a = dst_addr[s*5 +: 5];
            if (dst_valid[s] && a != 5'd0 &&
                ((e.urj && a == m_inst[9:5]) || (e.urk && a == m_inst[14:10])))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0; m_pc <= 32'h0; m_inst <= 32'h0;
            exp_q.delete();
        end else if (flush) begin
            m_valid <= 1'b0;
            exp_q.delete();
        end else if (!m_valid || (!model_hazard() && es_allowin)) begin
            m_valid <= fs_valid;
            if (fs_valid) begin
                m_pc <= fs_pc; m_inst <= fs_inst;
                exp_q.push_back(fs_pc);
                acc_cnt <= acc_cnt + 1;
            end
        end
    end

    // Compare process: every output against the model, mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic hz;
        if (chk_en) begin
            e  = m_valid ? model_decode(m_inst) : blank();
            hz = m_valid && model_hazard();
            chk("allowin", 32'(ds_allowin), 32'(!m_valid || (!hz && es_allowin)));
            chk("to_es_valid", 32'(ds_to_es_valid), 32'(m_valid && !hz && !flush));
            chk("ds_pc", ds_pc, m_pc);
            chk("dest", 32'(dest), 32'(m_inst[4:0]));
            chk("raddr1", 32'(rf_raddr1), 32'(m_inst[9:5]));
            chk("raddr2", 32'(rf_raddr2), 32'(m_inst[14:10]));
            chk("alu_op", 32'(alu_op), 32'(e.op));
            chk("rf_we", 32'(rf_we), 32'(e.we));
            chk("illegal", 32'(inst_illegal), 32'(m_valid && e.ill));
            if (!m_valid || !e.ill) begin
                chk("alu_src1", alu_src1, e.s1);
                chk("alu_src2", alu_src2, e.s2);
            end
            if (ds_to_es_valid && es_allowin) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL issue_spurious: pc %0h issued, nothing pending", ds_pc);
                end else begin
                    chk("issue_order", ds_pc, exp_q.pop_front());
                end
                issued_log.push_back(ds_pc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] ins);
        fs_valid = 1'b1; fs_pc = pc; fs_inst = ins;
        cyc();
        fs_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        int k;
        logic [4:0] rj, rk, rd;
        logic [11:0] i12;
        logic [19:0] i20;
        k = $urandom_range(0, 21);
        rj = 5'($urandom_range(0, 7));
        rk = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        i12 = 12'($urandom);
        i20 = 20'($urandom);
        if (k < 14)       return {OP3[k], rk, rj, rd};
        else if (k < 20)  return {OP2[k-14], i12, rj, rd};
        else if (k == 20) return {7'h0A, i20, rd};
        else              return $urandom;
    endfunction

    localparam logic [31:0] ADD_R3 = 32'h00100823;
    logic [31:0] b2b [4];
    logic        pat [4];

    initial begin
        regs[0] = 32'h0;
        for (int r = 1; r < 32; r++) regs[r] = $urandom;
        regs[1] = 32'd5; regs[2] = 32'd7;
        fs_valid = 1'b0; fs_pc = 32'h0; fs_inst = 32'h0; flush = 1'b0;
        dst_valid = '0; dst_addr = '0; es_allowin = 1'b1;

        repeat (2) cyc();
        chk_en = 1'b1;
        chk("rst_allowin", 32'(ds_allowin), 32'd1);
        chk("rst_to_es", 32'(ds_to_es_valid), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_src1", alu_src1, 32'd0);
        chk("rst_pc", ds_pc, 32'd0);
        resetn = 1'b1;

        // add.w r3,r1,r2
        load(32'h100, ADD_R3);
        chk("add_valid", 32'(ds_to_es_valid), 32'd1);
        chk("add_op", 32'(alu_op), 32'h001);
        chk("add_src2", alu_src2, 32'd5);
        chk("add_src1", alu_src1, 32'd7);
        chk("add_dest", 32'(dest), 32'd3);
        chk("add_we", 32'(rf_we), 32'd1);

        // immediates, back to back
        load(32'h104, {10'h00A, 12'hFFF, 5'd1, 5'd4});
        chk("addi_src1", alu_src1, 32'hFFFFFFFF);
        chk("addi_src2", alu_src2, 32'd5);
        load(32'h108, {7'h0A, 20'h12345, 5'd5});
        chk("lui_src2", alu_src2, 32'h12345000);
        chk("lui_op", 32'(alu_op), 32'h800);
        load(32'h10C, {17'h00081, 5'd4, 5'd1, 5'd6});
        chk("slli_src2", alu_src2, 32'd4);
        chk("slli_op", 32'(alu_op), 32'h100);
        chk("slli_src1", alu_src1, 32'd5);
        cyc();

        // RAW stall on rj via EX slot
        dst_valid = 3'b001; dst_addr = {5'd0, 5'd0, 5'd1};
        load(32'h200, ADD_R3);
        chk("raw_to_es", 32'(ds_to_es_valid), 32'd0);
        chk("raw_allowin", 32'(ds_allowin), 32'd0);
        cyc();
        chk("raw_hold_pc", ds_pc, 32'h200);
        chk("raw_hold_to_es", 32'(ds_to_es_valid), 32'd0);
        dst_valid = 3'b000;
        #1;
        chk("raw_clear_to_es", 32'(ds_to_es_valid), 32'd1);
        chk("raw_clear_allowin", 32'(ds_allowin), 32'd1);
        cyc();

        // back to back with EX backpressure 1,0,1,1
        issued_log.delete();
        b2b[0] = {17'h20, 5'd2, 5'd1, 5'd7};
        b2b[1] = {17'h22, 5'd4, 5'd3, 5'd8};
        b2b[2] = {17'h2A, 5'd6, 5'd5, 5'd9};
        b2b[3] = {10'h00F, 12'h0F0, 5'd2, 5'd10};
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        begin
            int base;
            int idx;
            base = acc_cnt;
            for (int c = 0; c < 10; c++) begin
                idx = acc_cnt - base;
                es_allowin = (c < 4) ? pat[c] : 1'b1;
                if (idx < 4) begin
                    fs_valid = 1'b1; fs_pc = 32'h300 + 32'(4 * idx); fs_inst = b2b[idx];
                end else begin
                    fs_valid = 1'b0;
                end
                cyc();
            end
        end
        fs_valid = 1'b0; es_allowin = 1'b1;
        chk("b2b_count", 32'(issued_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < issued_log.size(); k++)
            chk("b2b_pc", issued_log[k], 32'h300 + 32'(4 * k));

        // flush during a stall (rk hazard via MEM slot)
        dst_valid = 3'b010; dst_addr = {5'd0, 5'd2, 5'd0};
        load(32'h400, ADD_R3);
        chk("flush_stall_to_es", 32'(ds_to_es_valid), 32'd0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("flush_allowin", 32'(ds_allowin), 32'd1);
        chk("flush_op", 32'(alu_op), 32'd0);
        dst_valid = 3'b000;
        // flush coincident with a fetch loads nothing
        flush = 1'b1; fs_valid = 1'b1; fs_pc = 32'h500; fs_inst = ADD_R3;
        cyc();
        flush = 1'b0; fs_valid = 1'b0;
        chk("flush_load_to_es", 32'(ds_to_es_valid), 32'd0);
        chk("flush_load_pc", ds_pc, 32'h400);

        // illegal and rd=0
        load(32'h600, 32'hFFFFFFFF);
        chk("ill_flag", 32'(inst_illegal), 32'd1);
        chk("ill_op", 32'(alu_op), 32'd0);
        chk("ill_issues", 32'(ds_to_es_valid), 32'd1);
        load(32'h604, 32'h00100820);
        chk("rd0_we", 32'(rf_we), 32'd0);
        chk("rd0_op", 32'(alu_op), 32'h001);
        cyc();

        // async reset while stalled (rj hazard via WB slot)
        dst_valid = 3'b100; dst_addr = {5'd1, 5'd0, 5'd0};
        load(32'h700, ADD_R3);
        chk("rst_stall_pc", ds_pc, 32'h700);
        #2 resetn = 1'b0;
        #1;
        chk("arst_to_es", 32'(ds_to_es_valid), 32'd0);
        chk("arst_allowin", 32'(ds_allowin), 32'd1);
        chk("arst_op", 32'(alu_op), 32'd0);
        chk("arst_pc", ds_pc, 32'd0);
        chk("arst_dest", 32'(dest), 32'd0);
        dst_valid = 3'b000;
        cyc();
        resetn = 1'b1;

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) < 5) regs[$urandom_range(1, 31)] = $urandom;
            fs_valid   = ($urandom_range(0, 99) < 70);
            fs_pc      = $urandom & 32'hFFFFFFFC;
            fs_inst    = rand_inst();
            for (int s = 0; s < NF; s++) begin
                dst_valid[s]      = ($urandom_range(0, 99) < 25);
                dst_addr[s*5 +: 5] = 5'($urandom_range(0, 7));
            end
            es_allowin = ($urandom_range(0, 99) < 75);
            flush      = ($urandom_range(0, 99) < 5);
            cyc();
        end
        fs_valid = 1'b0; flush = 1'b0; dst_valid = '0; es_allowin = 1'b1;
        repeat (3) cyc();
        chk("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
